adsr_demux_2output_4bit: RTL and testbench
==========================================

# adsr_demux_2output_4bit

Registered 1-to-2 demultiplexer for 4-bit envelope/control samples in the ADSR path: steers a single valid/ready sample stream to one of two consumers (voice A / voice B). It is the fan-out counterpart of the 2-input 4-bit selector. Each output has a one-entry holding register and holds its last delivered value for DAC-style consumers. A per-output beat counter supports debug and verification.

## Interface
- WIDTH, 4, sample width in bits
- CNT_W, 8, beat counter width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- in_data  in  WIDTH  input sample
- in_valid  in  1  input sample present
- in_ready  out  1  block accepts in_data this cycle
- sel_req  in  1  requested destination: 0 = A, 1 = B
- active_sel  out  1  destination currently in force
- out_a_data / out_b_data  out  WIDTH  held sample per output
- out_a_valid / out_b_valid  out  1  holding register full
- out_a_ready / out_b_ready  in  1  consumer takes sample
- cnt_a / cnt_b  out  CNT_W  delivered-beat count per output

## Operation
- Input handshake: beat accepted when in_valid && in_ready.
- in_ready = (~V_sel) | R_sel. V_sel and R_sel are the valid and ready of the output chosen by active_sel. Purely combinational; no dependency on in_valid.
- An accepted beat loads the holding register of the active_sel output and sets its valid. The other output is untouched.
- Output handshake: out_x_valid && out_x_ready clears out_x_valid, unless a new beat loads x in the same cycle; then valid stays 1 with the new data.
- out_x_data is never cleared after delivery; it holds the last loaded value until the next load.
- cnt_x increments by 1 on each output handshake on x and wraps 2^CNT_W-1 -> 0.
- Select: active_sel <= sel_req every cycle (one-cycle registered switch).
  - A beat accepted in the same cycle as a change uses the old active_sel.
  - Switching never drops or moves an already-held sample; a full A register still drains to A after active_sel goes to B.
- States per output: EMPTY (valid=0) and FULL (valid=1).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load+drain, or on hold.

## Timing
- Reset values: active_sel=0, out_a_valid=out_b_valid=0, out_a_data=out_b_data=0, cnt_a=cnt_b=0. in_ready is 1 after reset.
- Latency: input accept at edge N -> out_x_valid=1 with the new data after edge N, visible in cycle N+1.
- Throughput: 1 beat/cycle to a single output whose consumer holds ready=1.
- Full with consumer stalled: in_ready=0. Input is held off and data is not overwritten.
- Reset mid-operation: held samples are discarded, counters zeroed, selection returns to A, all in the reset cycle.

## Structure
- Shared package adsr_pkg: WIDTH default, CNT_W default, localparam SEL_A=1'b0, SEL_B=1'b1.
- Sub-module out_hold_reg: one holding register with valid, data hold and beat counter; instantiated twice. The top level holds the select register and in_ready mux.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> all outputs at reset values, no load occurs; after release in_ready=1, active_sel=0.
- Steer A: sel_req=0, send 3,7,12 with out_a_ready=1 -> out_a_data 3,7,12 on consecutive cycles, cnt_a=3, out_b_valid stays 0, out_b_data=0.
- Switch mid-stream:
  - Send 5 to A with out_a_ready=0.
  - Set sel_req=1, send 9 -> out_b_data=9, out_a still FULL with 5.
  - Raise out_a_ready -> 5 delivered, cnt_a=1, cnt_b increments once out_b_ready=1.
- Backpressure: active_sel=1, out_b_ready=0, one beat loaded -> in_ready=0. A second beat of value 14 is held off and out_b_data keeps its first value until out_b_ready=1.
- Counter wrap: CNT_W=8, deliver 256 beats to A -> cnt_a returns to 0; out_a_data equals the 256th value.
- Reset mid-flight: both registers FULL, cnt_b=10, pulse rst_n=0 one cycle -> everything at reset values the following cycle.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared widths and destination encodings for the ADSR sample path.
package adsr_pkg;

    localparam int unsigned ADSR_WIDTH = 4;
    localparam int unsigned ADSR_CNT_W = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/adsr_demux_2output_4bit_out_hold_reg.sv
// One-entry output holding register with sticky data and a delivered-beat counter.
module out_hold_reg
    import adsr_pkg::*;
#(
    parameter int unsigned WIDTH = ADSR_WIDTH,
    parameter int unsigned CNT_W = ADSR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    logic drain;

    assign drain = valid & ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else begin
            // A load in the same cycle as a drain keeps the register full.
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
            if (drain) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adsr_demux_2output_4bit.sv
// Registered 1-to-2 demux steering a valid/ready 4-bit sample stream to voice A or B.
module adsr_demux_2output_4bit
    import adsr_pkg::*;
#(
    parameter int unsigned WIDTH = ADSR_WIDTH,
    parameter int unsigned CNT_W = ADSR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel_req,
    output logic             active_sel,
    output logic [WIDTH-1:0] out_a_data,
    output logic [WIDTH-1:0] out_b_data,
    output logic             out_a_valid,
    output logic             out_b_valid,
    input  logic             out_a_ready,
    input  logic             out_b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic accept;
    logic load_a;
    logic load_b;

    always_comb begin
        if (active_sel == SEL_B) begin
            in_ready = ~out_b_valid | out_b_ready;
        end else begin
            in_ready = ~out_a_valid | out_a_ready;
        end
    end

    assign accept = in_valid & in_ready;
    assign load_a = accept & (active_sel == SEL_A);
    assign load_b = accept & (active_sel == SEL_B);

    // Beats accepted during a select change still go to the old destination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_sel <= SEL_A;
        end else begin
            active_sel <= sel_req;
        end
    end

    out_hold_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_hold_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .ready     (out_a_ready),
        .data      (out_a_data),
        .valid     (out_a_valid),
        .cnt       (cnt_a)
    );

    out_hold_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_hold_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .ready     (out_b_ready),
        .data      (out_b_data),
        .valid     (out_b_valid),
        .cnt       (cnt_b)
    );

endmodule

// File: tb/tb_adsr_demux_2output_4bit.sv
// Directed, table-driven bench for adsr_demux_2output_4bit plus a counter-wrap sequence.
module tb_adsr_demux_2output_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sel_req;
    logic       active_sel;
    logic [3:0] out_a_data;
    logic [3:0] out_b_data;
    logic       out_a_valid;
    logic       out_b_valid;
    logic       out_a_ready;
    logic       out_b_ready;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adsr_demux_2output_4bit #(
        .WIDTH(4),
        .CNT_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel_req     (sel_req),
        .active_sel  (active_sel),
        .out_a_data  (out_a_data),
        .out_b_data  (out_b_data),
        .out_a_valid (out_a_valid),
        .out_b_valid (out_b_valid),
        .out_a_ready (out_a_ready),
        .out_b_ready (out_b_ready),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    typedef struct {
        bit         rst_n;
        bit         sel;
        bit         iv;
        logic [3:0] id;
        bit         ar;
        bit         br;
        bit         chk_rdy;
        bit         rdy;
        bit         esel;
        bit         eav;
        logic [3:0] ead;
        bit         ebv;
        logic [3:0] ebd;
        logic [7:0] eca;
        logic [7:0] ecb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit s, bit iv, logic [3:0] id, bit ar, bit br,
                                bit cr, bit rdy, bit esel, bit eav, logic [3:0] ead,
                                bit ebv, logic [3:0] ebd, logic [7:0] eca, logic [7:0] ecb);
        vec_t v;
        v.rst_n = r;  v.sel = s;  v.iv = iv;  v.id = id;  v.ar = ar;  v.br = br;
        v.chk_rdy = cr;  v.rdy = rdy;  v.esel = esel;
        v.eav = eav;  v.ead = ead;  v.ebv = ebv;  v.ebd = ebd;  v.eca = eca;  v.ecb = ecb;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [3:0] last_val;
        int stalls;

        //              rst sel iv id  ar br  cr rdy  esel av ad   bv bd   ca  cb
        vecs.push_back(mk(0, 0, 1, 15, 0, 0,  0, 0,   0,   0, 0,   0, 0,   0,  0)); // reset, 1st cycle
        vecs.push_back(mk(0, 0, 1, 15, 0, 0,  1, 1,   0,   0, 0,   0, 0,   0,  0)); // reset, no load
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  1, 1,   0,   0, 0,   0, 0,   0,  0));
        vecs.push_back(mk(1, 0, 1, 3,  1, 0,  1, 1,   0,   1, 3,   0, 0,   0,  0)); // steer A
        vecs.push_back(mk(1, 0, 1, 7,  1, 0,  1, 1,   0,   1, 7,   0, 0,   1,  0));
        vecs.push_back(mk(1, 0, 1, 12, 1, 0,  1, 1,   0,   1, 12,  0, 0,   2,  0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 0,  1, 1,   0,   0, 12,  0, 0,   3,  0));
        vecs.push_back(mk(1, 0, 1, 5,  0, 0,  1, 1,   0,   1, 5,   0, 0,   3,  0)); // A full, stalled
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  1, 0,   1,   1, 5,   0, 0,   3,  0)); // switch to B
        vecs.push_back(mk(1, 1, 1, 9,  0, 0,  1, 1,   1,   1, 5,   1, 9,   3,  0));
        vecs.push_back(mk(1, 1, 0, 0,  1, 0,  1, 0,   1,   0, 5,   1, 9,   4,  0)); // A drains late
        vecs.push_back(mk(1, 1, 0, 0,  0, 1,  1, 1,   1,   0, 5,   0, 9,   4,  1));
        vecs.push_back(mk(1, 1, 1, 2,  0, 0,  1, 1,   1,   0, 5,   1, 2,   4,  1)); // backpressure
        vecs.push_back(mk(1, 1, 1, 14, 0, 0,  1, 0,   1,   0, 5,   1, 2,   4,  1));
        vecs.push_back(mk(1, 1, 1, 14, 0, 0,  1, 0,   1,   0, 5,   1, 2,   4,  1));
        vecs.push_back(mk(1, 1, 1, 14, 0, 1,  1, 1,   1,   0, 5,   1, 14,  4,  2)); // load+drain
        vecs.push_back(mk(1, 1, 0, 0,  0, 1,  1, 1,   1,   0, 5,   0, 14,  4,  3));
        vecs.push_back(mk(1, 0, 1, 6,  0, 0,  1, 1,   0,   0, 5,   1, 6,   4,  3)); // old sel used
        vecs.push_back(mk(1, 0, 1, 8,  0, 0,  1, 1,   0,   1, 8,   1, 6,   4,  3));
        vecs.push_back(mk(0, 0, 1, 1,  1, 1,  1, 1,   0,   0, 0,   0, 0,   0,  0)); // reset mid-flight
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  1, 1,   0,   0, 0,   0, 0,   0,  0));

        rst_n = 1'b0; sel_req = 1'b0; in_valid = 1'b0; in_data = '0;
        out_a_ready = 1'b0; out_b_ready = 1'b0;

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;  sel_req = vecs[i].sel;  in_valid = vecs[i].iv;
            in_data = vecs[i].id;   out_a_ready = vecs[i].ar;  out_b_ready = vecs[i].br;
            #1;
            if (vecs[i].chk_rdy) check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d active_sel", i), 32'(active_sel), 32'(vecs[i].esel));
            check($sformatf("v%0d out_a_valid", i), 32'(out_a_valid), 32'(vecs[i].eav));
            check($sformatf("v%0d out_a_data", i), 32'(out_a_data), 32'(vecs[i].ead));
            check($sformatf("v%0d out_b_valid", i), 32'(out_b_valid), 32'(vecs[i].ebv));
            check($sformatf("v%0d out_b_data", i), 32'(out_b_data), 32'(vecs[i].ebd));
            check($sformatf("v%0d cnt_a", i), 32'(cnt_a), 32'(vecs[i].eca));
            check($sformatf("v%0d cnt_b", i), 32'(cnt_b), 32'(vecs[i].ecb));
        end

        // Counter wrap: 256 beats to A at full rate, starting from cnt_a=0.
        sel_req = 1'b0; out_a_ready = 1'b1; out_b_ready = 1'b0; in_valid = 1'b1;
        stalls = 0;
        last_val = '0;
        for (int i = 0; i < 256; i++) begin
            last_val = 4'((i * 7 + 3) & 15);
            in_data = last_val;
            #1;
            if (in_ready !== 1'b1) stalls++;
            @(posedge clk);
            #1;
        end
        check("wrap no_stall", 32'(stalls), 32'd0);
        check("wrap cnt_a_255", 32'(cnt_a), 32'd255);
        check("wrap out_a_data", 32'(out_a_data), 32'(last_val));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrap cnt_a_0", 32'(cnt_a), 32'd0);
        check("wrap out_a_valid", 32'(out_a_valid), 32'd0);
        check("wrap out_a_hold", 32'(out_a_data), 32'(last_val));
        check("wrap cnt_b", 32'(cnt_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
